// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------------------------------------------------------------------
// Pipeline stage register with a valid/ready handshake. It replaces the plain
// enable/flush latch between pipeline stages.
//
// With SKID=1 the stage holds up to two entries: a main register M that
// drives the outputs and a skid register S. in_ready is registered, so there
// is no combinational path from out_ready to in_ready.
//
// With SKID=0 only M exists, and in_ready is the combinational
// !out_valid | out_ready.
//
// Control bits are stored ANDed with valid. A bubble therefore always
// carries ctrl = 0, so a stall or a flush can never leak a write enable
// downstream.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous reset, active-high (takes priority over flush)
//   flush      synchronous kill of all held entries and of the input beat
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload [DATA_W]
//   in_ctrl    upstream control bits [CTRL_W]
//   out_valid  output beat valid
//   out_ready  downstream accepts
//   out_data   output payload [DATA_W]
//   out_ctrl   output control bits [CTRL_W]; zero whenever out_valid=0
//   count      number of entries held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W     = 69,
  parameter int CTRL_W     = 4,
  parameter int SKID       = 1,
  parameter int FLUSH_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  // Main (older) entry and skid (younger) entry.
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;

  logic              w_m_valid_next;
  logic [DATA_W-1:0] w_m_data_next;
  logic [CTRL_W-1:0] w_m_ctrl_next;
  logic              w_s_valid_next;
  logic [DATA_W-1:0] w_s_data_next;
  logic [CTRL_W-1:0] w_s_ctrl_next;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_emit;

  // A beat presented during a flush is dropped even if in_ready is high.
  assign w_accept = in_valid && w_in_ready && !flush;
  assign w_emit   = r_m_valid && out_ready;

  // The emit is applied first, then the accept fills whichever slot is free.
  // This single rule covers every transition:
  //   ONE  with accept and emit  -> M is replaced.
  //   ONE  with accept only      -> the beat goes to S.
  //   FULL with emit             -> S is promoted into M.
  // FULL never accepts, because in_ready is low there. The SKID=0 build never
  // reaches the S path, because M is only loaded when it is empty or
  // draining.
  always_comb begin
    w_m_valid_next = r_m_valid;
    w_m_data_next  = r_m_data;
    w_m_ctrl_next  = r_m_ctrl;
    w_s_valid_next = r_s_valid;
    w_s_data_next  = r_s_data;
    w_s_ctrl_next  = r_s_ctrl;

    if (w_emit) begin
      if (r_s_valid) begin
        w_m_valid_next = 1'b1;
        w_m_data_next  = r_s_data;
        w_m_ctrl_next  = r_s_ctrl;
        w_s_valid_next = 1'b0;
        w_s_ctrl_next  = '0;
      end else begin
        // Payload is left stale; only valid and ctrl are cleared.
        w_m_valid_next = 1'b0;
        w_m_ctrl_next  = '0;
      end
    end

    if (w_accept) begin
      if (!w_m_valid_next) begin
        w_m_valid_next = 1'b1;
        w_m_data_next  = in_data;
        w_m_ctrl_next  = in_ctrl;
      end else begin
        w_s_valid_next = 1'b1;
        w_s_data_next  = in_data;
        w_s_ctrl_next  = in_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_m_valid <= 1'b0;
      r_m_ctrl  <= '0;
      r_s_valid <= 1'b0;
      r_s_ctrl  <= '0;
      if (FLUSH_DATA != 0) begin
        r_m_data <= '0;
        r_s_data <= '0;
      end
    end else begin
      r_m_valid <= w_m_valid_next;
      r_m_data  <= w_m_data_next;
      r_m_ctrl  <= w_m_ctrl_next;
      r_s_valid <= w_s_valid_next;
      r_s_data  <= w_s_data_next;
      r_s_ctrl  <= w_s_ctrl_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      // in_ready is computed from the next occupancy, so it is a pure flop
      // output.
      logic r_in_ready;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= !(w_m_valid_next && w_s_valid_next);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_noskid
      assign w_in_ready = !r_m_valid || out_ready;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_ctrl;
  assign count     = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid.
//
// Two instances share one set of stimulus:
//   dut1  SKID=1, FLUSH_DATA=1
//   dut0  SKID=0, FLUSH_DATA=0
//
// Each instance is checked against a FIFO-queue reference model of the
// handshake rules. dut1 is also checked against a hand-computed vector table.
module tb_pipe_stage_skid;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;

  logic          in_ready1;
  logic          out_valid1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] out_ctrl1;
  logic [1:0]    count1;

  logic          in_ready0;
  logic          out_valid0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    count0;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(1), .FLUSH_DATA(1)
  ) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ctrl(out_ctrl1),
    .count(count1)
  );

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(0), .FLUSH_DATA(0)
  ) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ctrl(out_ctrl0),
    .count(count0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: each entry is {ctrl, data}.
  // q1 holds at most two entries; q0 holds at most one.
  logic [CW+DW-1:0] q1[$];
  logic [CW+DW-1:0] q0[$];
  bit               zero1      = 1'b0; // dut1 payload zeroed by rst/flush, nothing loaded since
  bit               seen_reset = 1'b0;

  typedef struct {
    logic          r;
    logic          fl;
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic          chk_d;
    logic [CW-1:0] oc;
    logic [1:0]    cnt;
    logic          ir;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle.
  // Drives the inputs, checks the combinational ready of dut0, advances the
  // model, then compares both DUTs just after the edge.
  task automatic step(input logic r, input logic fl, input logic iv,
                      input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy);
    bit               ir1, ir0, em1, em0, ac1, ac0;
    logic [CW+DW-1:0] dummy;

    rst       = r;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    #1;

    ir1 = (q1.size() < 2);
    ir0 = (q0.size() == 0) || ordy;
    if (seen_reset) chk("in_ready0_comb", {31'd0, in_ready0}, {31'd0, ir0});

    em1 = (q1.size() > 0) && ordy;
    em0 = (q0.size() > 0) && ordy;
    ac1 = iv && ir1 && !fl;
    ac0 = iv && ir0 && !fl;

    if (r || fl) begin
      q1.delete();
      q0.delete();
      zero1 = 1'b1;
    end else begin
      if (em1) dummy = q1.pop_front();
      if (ac1) begin
        q1.push_back({c, d});
        zero1 = 1'b0;
      end
      if (em0) dummy = q0.pop_front();
      if (ac0) q0.push_back({c, d});
    end

    @(posedge clk);
    #1;
    if (r) seen_reset = 1'b1;

    $display("t=%0t rst=%0b fl=%0b in=%0b/%0h/%0h ordy=%0b | s1 v=%0b d=%0h c=%0h n=%0d ir=%0b | s0 v=%0b d=%0h c=%0h n=%0d",
             $time, r, fl, iv, d, c, ordy,
             out_valid1, out_data1, out_ctrl1, count1, in_ready1,
             out_valid0, out_data0, out_ctrl0, count0);

    // SKID=1 instance.
    chk("s1_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() > 0});
    chk("s1_count", {30'd0, count1}, q1.size());
    chk("s1_in_ready", {31'd0, in_ready1}, {31'd0, q1.size() < 2});
    if (q1.size() > 0) begin
      chk("s1_out_data", {24'd0, out_data1}, {24'd0, q1[0][DW-1:0]});
      chk("s1_out_ctrl", {28'd0, out_ctrl1}, {28'd0, q1[0][CW+DW-1:DW]});
    end else begin
      chk("s1_bubble_ctrl", {28'd0, out_ctrl1}, 32'd0);
      if (zero1) chk("s1_zeroed_data", {24'd0, out_data1}, 32'd0);
    end

    // SKID=0 instance.
    chk("s0_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() > 0});
    chk("s0_count", {30'd0, count0}, q0.size());
    if (q0.size() > 0) begin
      chk("s0_out_data", {24'd0, out_data0}, {24'd0, q0[0][DW-1:0]});
      chk("s0_out_ctrl", {28'd0, out_ctrl0}, {28'd0, q0[0][CW+DW-1:DW]});
    end else begin
      chk("s0_bubble_ctrl", {28'd0, out_ctrl0}, 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;

    // Hand-computed expectations for the SKID=1, FLUSH_DATA=1 instance.
    // Fields: rst fl iv d c ordy | ov od chk_d oc cnt ir
    // Reset held for two cycles with garbage on the inputs.
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hAA, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hAA, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    // Bubbles carrying ctrl=1111 must stay invisible.
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h5A, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h5A, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h5A, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    // Backpressure: A and B are held, C is refused.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h11, 4'h9, 1'b0,  1'b1, 8'h11, 1'b1, 4'h9, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h22, 4'h9, 1'b0,  1'b1, 8'h11, 1'b1, 4'h9, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 4'h9, 1'b0,  1'b1, 8'h11, 1'b1, 4'h9, 2'd2, 1'b0});
    // Release: A leaves, B moves up, then C follows.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 4'h9, 1'b1,  1'b1, 8'h22, 1'b1, 4'h9, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 4'h9, 1'b1,  1'b1, 8'h33, 1'b1, 4'h9, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1,  1'b0, 8'h00, 1'b0, 4'h0, 2'd0, 1'b1});
    // Fill the stage, then flush it with D=0x44 presented in the same cycle.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h55, 4'h3, 1'b0,  1'b1, 8'h55, 1'b1, 4'h3, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h66, 4'h3, 1'b0,  1'b1, 8'h55, 1'b1, 4'h3, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h44, 4'hF, 1'b0,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h44, 4'hF, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    // Flush coinciding with an output handshake and an input beat.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h77, 4'h1, 1'b1,  1'b1, 8'h77, 1'b1, 4'h1, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h88, 4'h1, 1'b1,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});
    // Reset beats an accept.
    tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h99, 4'h2, 1'b1,  1'b1, 8'h99, 1'b1, 4'h2, 2'd1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 8'hAB, 4'h2, 1'b0,  1'b0, 8'h00, 1'b1, 4'h0, 2'd0, 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
      chk("tbl_out_valid", {31'd0, out_valid1}, {31'd0, tbl[i].ov});
      chk("tbl_out_ctrl", {28'd0, out_ctrl1}, {28'd0, tbl[i].oc});
      chk("tbl_count", {30'd0, count1}, {30'd0, tbl[i].cnt});
      chk("tbl_in_ready", {31'd0, in_ready1}, {31'd0, tbl[i].ir});
      if (tbl[i].chk_d) chk("tbl_out_data", {24'd0, out_data1}, {24'd0, tbl[i].od});
    end

    // Streaming: back-to-back beats with 1-cycle latency and no gaps.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, i[7:0], 4'b1001, 1'b1);
      chk("stream_data", {24'd0, out_data1}, i);
      chk("stream_count", {30'd0, count1}, 32'd1);
      chk("stream_valid", {31'd0, out_valid1}, 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 1'b1);

    // SKID=0: continuous input while out_ready toggles.
    // The model checks the combinational in_ready and that no beat is lost.
    begin
      logic tog[6];
      tog = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 1'b0, 1'b1, 8'hC0 + i[7:0], 4'h5, tog[i]);
        chk("s0_count_le1", {31'd0, count0 > 2'd1}, 32'd0);
      end
    end

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0), 8'($urandom), 4'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
